// File: rtl/rom_port_arbiter_pkg.sv
// rom_port_arbiter_pkg: shared state encodings, port IDs and the ROM address check
package rom_port_arbiter_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;
    typedef enum logic {PORT_IF = 1'b0, PORT_LD = 1'b1} port_t;
    localparam logic [31:0] DEFAULT_INIT_PC = 32'h0000_1000;
    // Offset compare wraps at 32 bits, so addresses below base are out of range
    function automatic logic rom_addr_err(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] size);
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || (off >= size);
    endfunction
endpackage

// File: rtl/rom_rr_arbiter2.sv
// rom_rr_arbiter2: 2-way grant, round-robin or fixed LD-over-IF priority
module rom_rr_arbiter2
    import rom_port_arbiter_pkg::*;
#(
    parameter int RR_ARB = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  req_if,
    input  logic  req_ld,
    input  logic  accept,
    output logic  grant_valid,
    output port_t grant_port
);
    port_t ptr;
    always_comb begin
        grant_valid = req_if || req_ld;
        grant_port  = (req_if && req_ld) ? ((RR_ARB != 0) ? ptr : PORT_LD) : (req_ld ? PORT_LD : PORT_IF);
    end
    // ptr names the port preferred on the next contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= PORT_IF;
        else if (accept)
            ptr <= (grant_port == PORT_IF) ? PORT_LD : PORT_IF;
    end
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one synchronous ROM between IF and LD requesters
// with valid/ready handshakes, address checking and IF flush.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter logic [31:0] INIT_PC   = DEFAULT_INIT_PC,
    parameter int          ROM_BYTES = 1024,
    parameter int          RR_ARB    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_resp_valid,
    input  logic        if_resp_ready,
    output logic [31:0] if_resp_data,
    output logic        if_resp_err,
    input  logic        if_flush,
    input  logic        ld_req_valid,
    output logic        ld_req_ready,
    input  logic [31:0] ld_req_addr,
    output logic        ld_resp_valid,
    input  logic        ld_resp_ready,
    output logic [31:0] ld_resp_data,
    output logic        ld_resp_err,
    output logic        rom_en,
    output logic [3:0]  rom_write_en,
    output logic [31:0] rom_addr,
    output logic [31:0] rom_write_data,
    input  logic [31:0] rom_read_data
);
    state_t      state, state_nx;
    port_t       owner, grant_port;
    logic        err_q, grant_valid, accept, req_err, resp_done, arb_open, owner_if;
    logic [31:0] hold, grant_addr;

    rom_rr_arbiter2 #(.RR_ARB(RR_ARB)) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_if     (if_req_valid && !if_flush),
        .req_ld     (ld_req_valid),
        .accept     (accept),
        .grant_valid(grant_valid),
        .grant_port (grant_port)
    );

    always_comb begin
        owner_if       = (owner == PORT_IF);
        resp_done      = (state == ST_RESP) && (owner_if ? (if_resp_ready && !if_flush) : ld_resp_ready);
        arb_open       = rst_n && ((state == ST_IDLE) || resp_done);
        accept         = arb_open && grant_valid;
        grant_addr     = (grant_port == PORT_LD) ? ld_req_addr : if_req_addr;
        req_err        = rom_addr_err(grant_addr, INIT_PC, 32'(ROM_BYTES));
        if_req_ready   = accept && (grant_port == PORT_IF);
        ld_req_ready   = accept && (grant_port == PORT_LD);
        rom_en         = accept && !req_err;
        rom_addr       = rom_en ? grant_addr : 32'h0;
        rom_write_en   = 4'h0;
        rom_write_data = 32'h0;
        if_resp_valid  = (state == ST_RESP) && owner_if;
        ld_resp_valid  = (state == ST_RESP) && !owner_if;
        if_resp_data   = if_resp_valid ? hold : 32'h0;
        ld_resp_data   = ld_resp_valid ? hold : 32'h0;
        if_resp_err    = if_resp_valid && err_q;
        ld_resp_err    = ld_resp_valid && err_q;
    end

    // A flush of an IF-owned transaction abandons it without a response
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  state_nx = accept ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nx = (owner_if && if_flush) ? ST_IDLE : ST_RESP;
            ST_RESP:  state_nx = accept ? ST_ISSUE : ((resp_done || (owner_if && if_flush)) ? ST_IDLE : ST_RESP);
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            owner <= PORT_IF;
            err_q <= 1'b0;
            hold  <= 32'h0;
        end else begin
            state <= state_nx;
            if (accept) begin
                owner <= grant_port;
                err_q <= req_err;
            end
            if (state == ST_ISSUE)
                hold <= err_q ? 32'h0 : rom_read_data;
        end
    end
endmodule
